// File: rtl/mem_arbiter.sv
// Arbitrates one byte-wide synchronous-read RAM between the CPU and a DMA master.
// The CPU has priority. A starvation counter forces bounded DMA bursts.
module mem_arbiter #(
    parameter int unsigned AW     = 20,
    parameter int unsigned STARVE = 8,
    parameter int unsigned BURST  = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_address,
    input  logic [7:0]    cpu_o_data,
    input  logic          cpu_we,
    output logic          cpu_ready,
    output logic [7:0]    cpu_i_data,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_address,
    input  logic [7:0]    dma_wdata,
    input  logic          dma_we,
    output logic          dma_ack,
    output logic          dma_rvalid,
    output logic [7:0]    dma_rdata,
    output logic [AW-1:0] mem_address,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    input  logic [7:0]    mem_rdata
);
    localparam int unsigned SW = $clog2(STARVE + 1);
    localparam int unsigned BW = $clog2(BURST + 1);

    typedef enum logic {CPU_PRI, DMA_BURST} state_e;
    typedef enum logic [1:0] {RD_NONE, RD_CPU, RD_DMA} rd_e;

    state_e        state_q, state_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d, starve_inc;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d, burst_inc;
    rd_e           rd_q, rd_d;
    logic          grant_cpu, grant_dma;

    // State, counters and the owner/read-ness of the last accepted access.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= CPU_PRI;
            starve_cnt_q <= '0;
            burst_cnt_q  <= '0;
            rd_q         <= RD_NONE;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            rd_q         <= rd_d;
        end
    end

    // Owner selection and next-state logic.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        grant_cpu    = 1'b0;
        grant_dma    = 1'b0;
        starve_inc   = starve_cnt_q + SW'(1);
        burst_inc    = burst_cnt_q + BW'(1);

        if (!dma_req) begin
            starve_cnt_d = '0;
        end

        if (state_q == DMA_BURST && dma_req) begin
            grant_dma = 1'b1;
            if (burst_inc == BW'(BURST)) begin
                state_d      = CPU_PRI;
                starve_cnt_d = '0;
                burst_cnt_d  = '0;
            end else begin
                burst_cnt_d = burst_inc;
            end
        end else begin
            // An abandoned DMA window hands this very cycle back to the CPU.
            state_d     = CPU_PRI;
            burst_cnt_d = '0;
            if (cpu_req) begin
                grant_cpu = 1'b1;
                if (dma_req) begin
                    starve_cnt_d = starve_inc;
                    if (starve_inc == SW'(STARVE)) begin
                        state_d = DMA_BURST;
                    end
                end
            end else if (dma_req) begin
                grant_dma    = 1'b1;
                starve_cnt_d = '0;
            end
        end

        if (!reset_n) begin
            grant_cpu = 1'b0;
            grant_dma = 1'b0;
        end
    end

    // Memory mux; the CPU address idles on the bus when nobody owns it.
    always_comb begin
        mem_address = grant_dma ? dma_address : cpu_address;
        mem_wdata   = grant_dma ? dma_wdata : cpu_o_data;
        mem_we      = (grant_cpu & cpu_we) | (grant_dma & dma_we);
        cpu_ready   = grant_cpu;
        dma_ack     = grant_dma;
        rd_d        = RD_NONE;
        if (grant_cpu && !cpu_we) begin
            rd_d = RD_CPU;
        end else if (grant_dma && !dma_we) begin
            rd_d = RD_DMA;
        end
    end

    assign dma_rvalid = (rd_q == RD_DMA);
    assign dma_rdata  = mem_rdata;
    assign cpu_i_data = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, every cycle
// compared against a priority/starvation model and a shadow memory.
module tb_mem_arbiter;
    localparam int unsigned AW     = 20;
    localparam int unsigned STARVE = 8;
    localparam int unsigned BURST  = 4;

    logic          clock, reset_n;
    logic          cpu_req, cpu_we, cpu_ready;
    logic [AW-1:0] cpu_address;
    logic [7:0]    cpu_o_data, cpu_i_data;
    logic          dma_req, dma_we, dma_ack, dma_rvalid;
    logic [AW-1:0] dma_address;
    logic [7:0]    dma_wdata, dma_rdata;
    logic [AW-1:0] mem_address;
    logic [7:0]    mem_wdata, mem_rdata;
    logic          mem_we;

    bit [7:0] ram    [0:(1<<AW)-1];
    bit [7:0] shadow [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    // model state
    int       forced_left = 0;
    int       streak      = 0;
    bit       pend_cpu    = 1'b0;
    bit       pend_dma    = 1'b0;
    bit [7:0] pend_data   = 8'h00;

    mem_arbiter #(.AW(AW), .STARVE(STARVE), .BURST(BURST)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_req     (cpu_req),
        .cpu_address (cpu_address),
        .cpu_o_data  (cpu_o_data),
        .cpu_we      (cpu_we),
        .cpu_ready   (cpu_ready),
        .cpu_i_data  (cpu_i_data),
        .dma_req     (dma_req),
        .dma_address (dma_address),
        .dma_wdata   (dma_wdata),
        .dma_we      (dma_we),
        .dma_ack     (dma_ack),
        .dma_rvalid  (dma_rvalid),
        .dma_rdata   (dma_rdata),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #20 clock = ~clock;
    end

    // Synchronous-read RAM.
    always @(posedge clock) begin
        if (mem_we) ram[mem_address] <= mem_wdata;
        mem_rdata <= ram[mem_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference model and per-cycle comparison.
    always @(negedge clock) begin
        bit            exp_cpu, exp_dma, exp_we;
        logic [AW-1:0] exp_addr;
        if (!reset_n) begin
            chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
            chk("rst_dma_ack", 32'(dma_ack), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            chk("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
            forced_left = 0;
            streak      = 0;
            pend_cpu    = 1'b0;
            pend_dma    = 1'b0;
        end else begin
            exp_cpu = 1'b0;
            exp_dma = 1'b0;
            if (forced_left > 0 && dma_req) begin
                exp_dma = 1'b1;
            end else begin
                forced_left = 0;
                if (cpu_req) exp_cpu = 1'b1;
                else if (dma_req) exp_dma = 1'b1;
            end
            exp_we   = (exp_cpu && cpu_we) || (exp_dma && dma_we);
            exp_addr = exp_dma ? dma_address : cpu_address;

            chk("cpu_ready", 32'(cpu_ready), 32'(exp_cpu));
            chk("dma_ack", 32'(dma_ack), 32'(exp_dma));
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            chk("mem_address", 32'(mem_address), 32'(exp_addr));
            if (exp_we) chk("mem_wdata", 32'(mem_wdata), 32'(exp_dma ? dma_wdata : cpu_o_data));
            chk("dma_rvalid", 32'(dma_rvalid), 32'(pend_dma));
            if (pend_dma) chk("dma_rdata", 32'(dma_rdata), 32'(pend_data));
            if (pend_cpu) chk("cpu_i_data", 32'(cpu_i_data), 32'(pend_data));

            pend_cpu  = exp_cpu && !cpu_we;
            pend_dma  = exp_dma && !dma_we;
            pend_data = shadow[exp_addr];
            if (exp_we) shadow[exp_addr] = exp_dma ? dma_wdata : cpu_o_data;

            if (exp_dma && forced_left > 0) begin
                forced_left--;
            end else if (exp_cpu && dma_req) begin
                streak++;
                if (streak == int'(STARVE)) begin
                    forced_left = int'(BURST);
                    streak      = 0;
                end
            end else begin
                streak = 0;
            end
        end
    end

    initial begin
        int nc, nd, nw;
        bit c_ack, d_ack;
        reset_n     = 1'b1;
        cpu_req     = 1'b0;
        cpu_we      = 1'b0;
        cpu_address = '0;
        cpu_o_data  = 8'h00;
        dma_req     = 1'b0;
        dma_we      = 1'b0;
        dma_address = '0;
        dma_wdata   = 8'h00;
        ram[20'h12345] <= 8'hA5;
        shadow[20'h12345] = 8'hA5;

        // Reset gates the strobes even with requests present.
        #1 reset_n = 1'b0;
        cpu_req = 1'b1;
        dma_req = 1'b1;
        dma_we  = 1'b1;
        #1;
        chk("reset_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("reset_dma_ack", 32'(dma_ack), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_dma_rvalid", 32'(dma_rvalid), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        cpu_req = 1'b0;
        dma_req = 1'b0;
        dma_we  = 1'b0;
        reset_n = 1'b1;
        step();

        // CPU only read.
        cpu_req     = 1'b1;
        cpu_address = 20'h12345;
        cpu_we      = 1'b0;
        #1;
        chk("t1_cpu_ready", 32'(cpu_ready), 32'd1);
        chk("t1_mem_address", 32'(mem_address), 32'h12345);
        chk("t1_dma_ack", 32'(dma_ack), 32'd0);
        step();
        cpu_req = 1'b0;
        #1;
        chk("t1_cpu_i_data", 32'(cpu_i_data), 32'hA5);
        chk("t1_dma_rvalid", 32'(dma_rvalid), 32'd0);
        step();

        // DMA write then read back.
        dma_req     = 1'b1;
        dma_address = 20'h00400;
        dma_wdata   = 8'h3C;
        dma_we      = 1'b1;
        #1;
        chk("t2_wr_ack", 32'(dma_ack), 32'd1);
        chk("t2_wr_mem_we", 32'(mem_we), 32'd1);
        chk("t2_wr_addr", 32'(mem_address), 32'h00400);
        step();
        dma_we = 1'b0;
        #1;
        chk("t2_rd_ack", 32'(dma_ack), 32'd1);
        chk("t2_rd_mem_we", 32'(mem_we), 32'd0);
        step();
        dma_req = 1'b0;
        #1;
        chk("t2_rvalid", 32'(dma_rvalid), 32'd1);
        chk("t2_rdata", 32'(dma_rdata), 32'h3C);
        step();

        // Continuous contention: 8 CPU, 4 DMA, repeating.
        cpu_req     = 1'b1;
        cpu_we      = 1'b0;
        cpu_address = 20'h00100;
        dma_req     = 1'b1;
        dma_we      = 1'b0;
        dma_address = 20'h00200;
        for (int i = 0; i < 24; i++) begin
            #1;
            chk($sformatf("t3_cpu_grant_%0d", i), 32'(cpu_ready), 32'((i % 12) < 8));
            chk($sformatf("t3_dma_grant_%0d", i), 32'(dma_ack), 32'((i % 12) >= 8));
            step();
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        step();

        // DMA drops mid-burst.
        cpu_req = 1'b1;
        dma_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 chk("t4_cpu_pre", 32'(cpu_ready), 32'd1);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            #1 chk("t4_dma_burst", 32'(dma_ack), 32'd1);
            step();
        end
        dma_req = 1'b0;
        #1 chk("t4_cpu_on_drop", 32'(cpu_ready), 32'd1);
        step();
        dma_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 chk($sformatf("t4_cpu_again_%0d", i), 32'(cpu_ready), 32'd1);
            step();
        end
        #1 chk("t4_dma_after_8", 32'(dma_ack), 32'd1);
        step();
        cpu_req = 1'b0;
        dma_req = 1'b0;
        step();

        // Async reset in the cycle after a DMA read ack, from inside a DMA window.
        cpu_req     = 1'b1;
        cpu_we      = 1'b0;
        dma_req     = 1'b1;
        dma_we      = 1'b0;
        dma_address = 20'h00400;
        repeat (8) step();
        #1 chk("t5_dma_read_ack", 32'(dma_ack), 32'd1);
        step();
        #1 chk("t5_rvalid_before", 32'(dma_rvalid), 32'd1);
        reset_n = 1'b0;
        dma_we  = 1'b1;
        #1;
        chk("t5_rvalid_reset", 32'(dma_rvalid), 32'd0);
        chk("t5_mem_we_reset", 32'(mem_we), 32'd0);
        chk("t5_dma_ack_reset", 32'(dma_ack), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        dma_we  = 1'b0;
        #1;
        chk("t5_cpu_first", 32'(cpu_ready), 32'd1);
        chk("t5_dma_not_first", 32'(dma_ack), 32'd0);
        step();
        cpu_req = 1'b0;
        dma_req = 1'b0;
        step();

        // Competing writes to one address.
        cpu_req     = 1'b1;
        cpu_we      = 1'b1;
        cpu_address = 20'h00010;
        cpu_o_data  = 8'h11;
        dma_req     = 1'b1;
        dma_we      = 1'b1;
        dma_address = 20'h00010;
        dma_wdata   = 8'h22;
        nc = 0; nd = 0; nw = 0;
        for (int i = 0; i < 9; i++) begin
            #1;
            if (cpu_ready) nc++;
            if (dma_ack) nd++;
            if (mem_we) nw++;
            step();
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        #1;
        chk("t6_cpu_writes", 32'(nc), 32'd8);
        chk("t6_dma_writes", 32'(nd), 32'd1);
        chk("t6_we_pulses", 32'(nw), 32'd9);
        chk("t6_final_ram", 32'(ram[20'h00010]), 32'h22);
        step();

        // Random traffic obeying the hold-until-accepted handshake.
        cpu_req = 1'b0;
        dma_req = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            c_ack = cpu_ready;
            d_ack = dma_ack;
            @(posedge clock);
            #1;
            if (!cpu_req || c_ack) begin
                cpu_req     = ($urandom_range(0, 3) != 0);
                cpu_address = AW'($urandom_range(0, 31));
                cpu_we      = 1'($urandom_range(0, 1));
                cpu_o_data  = 8'($urandom);
            end
            if (dma_req && !d_ack) begin
                if ($urandom_range(0, 15) == 0) dma_req = 1'b0;
            end else begin
                dma_req     = ($urandom_range(0, 2) != 0);
                dma_address = AW'($urandom_range(0, 31));
                dma_we      = 1'($urandom_range(0, 1));
                dma_wdata   = 8'($urandom);
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single byte-wide system RAM (20-bit address, 8-bit data, synchronous read) between the CPU bus master and a secondary DMA/video-fetch master. Sits between cpu, RAM and the DMA engine, and issues at most one memory access per clock. CPU has priority, bounded by a starvation counter that forces fixed-length DMA bursts. The CPU is stalled via cpu_ready while it does not own the bus.

Parameters:
AW, 20, address width in bits.
STARVE, 8, max consecutive CPU grants while dma_req is pending (≥1).
BURST, 4, max consecutive DMA accesses per forced DMA window (≥1).

Ports:
clock  in  1  system clock, 25 MHz, all state on posedge.
reset_n  in  1  asynchronous, active-low reset.
cpu_req  in  1  CPU requests an access this cycle.
cpu_address  in  AW  CPU byte address.
cpu_o_data  in  8  CPU write data.
cpu_we  in  1  CPU write enable (qualified by cpu_req).
cpu_ready  out  1  CPU access accepted this cycle; CPU holds all cpu_* inputs while low.
cpu_i_data  out  8  read data, valid the cycle after an accepted CPU read.
dma_req  in  1  DMA requests an access.
dma_address  in  AW  DMA byte address.
dma_wdata  in  8  DMA write data.
dma_we  in  1  DMA write enable.
dma_ack  out  1  DMA access accepted this cycle; DMA holds inputs until ack.
dma_rvalid  out  1  pulse, cycle after an accepted DMA read.
dma_rdata  out  8  DMA read data, valid with dma_rvalid.
mem_address  out  AW  RAM address.
mem_wdata  out  8  RAM write data.
mem_we  out  1  RAM write strobe.
mem_rdata  in  8  RAM read data, one cycle after address.

Behaviour:
- Reset (reset_n=0, async): state=CPU_PRI, starve_cnt=0, burst_cnt=0, dma_rvalid=0. cpu_ready, dma_ack and mem_we are forced to 0 while reset_n=0. Any in-flight access is dropped and no rvalid follows.
- Owner is chosen combinationally from the registered state and the current requests. mem_address, mem_wdata and mem_we are muxed from the owner. cpu_ready/dma_ack are asserted in the same cycle as the access.
- No requester: mem_address=cpu_address, mem_we=0, both acks 0. No counters change.
- CPU_PRI:
  - cpu_req only → CPU granted. starve_cnt is unchanged (it is 0 unless dma_req was pending).
  - dma_req only → DMA granted. starve_cnt←0.
  - both requesters, starve_cnt<STARVE → CPU granted, starve_cnt++. When the incremented value equals STARVE, the next state is DMA_BURST with burst_cnt←0.
  - dma_req low in any cycle → starve_cnt←0.
- DMA_BURST:
  - dma_req=1 → DMA granted even if cpu_req=1, and burst_cnt++. When burst_cnt reaches BURST, return to CPU_PRI with starve_cnt←0.
  - dma_req=0 → return to CPU_PRI immediately (combinationally, same cycle). The CPU is served if it requests. starve_cnt←0.
- Read return:
  - A registered flag records the owner and read-ness of the accepted access.
  - cpu_i_data=mem_rdata always, meaningful only the cycle after an accepted CPU read.
  - dma_rvalid=1 exactly one cycle after an accepted DMA read (dma_we=0); dma_rdata=mem_rdata.
  - Writes produce no rvalid.
- Latency: a grant is zero-wait when uncontended. Read data arrives 1 cycle after the accept. Under contention, worst-case CPU stall is BURST cycles and worst-case DMA wait is STARVE cycles.
- Requester dropping its request without ack is legal; no state is kept for it.
- Counters saturate by construction and never wrap.

Test Plan:
- CPU only: cpu_req=1 reading 0x12345, RAM holds 0xA5 → cpu_ready=1 same cycle, mem_address=0x12345, cpu_i_data=0xA5 next cycle. dma_ack and dma_rvalid stay 0.
- DMA only: write 0x3C to 0x00400, then read it back → dma_ack=1 on both cycles, mem_we=1 only on the first. dma_rvalid=1 with dma_rdata=0x3C the cycle after the read.
- Contention, STARVE=8, BURST=4, both requesting continuously:
  - First pattern: 8 CPU grants, then 4 DMA grants (cpu_ready=0 for those 4 cycles), then 8 CPU grants, repeating.
  - Check the exact grant cycle indices.
- DMA drops mid-burst: dma_req falls after 2 DMA grants → CPU granted in that same cycle, and the next contention needs a full 8 CPU grants again.
- Async reset mid-DMA-read: reset_n asserted in the cycle after a DMA read ack → dma_rvalid=0 immediately, mem_we=0. After release, both requesting → CPU granted first (state CPU_PRI, counters 0).
- Write protect on arbitration: both request, CPU write 0x11 to 0x00010 and DMA write 0x22 to 0x00010 → CPU write wins first, the DMA write lands after the starvation window. Final RAM value is 0x22, and exactly one mem_we pulse occurs per ack.
